knn_train_loader: RTL
=====================

# knn_train_loader

Front-end stage for the k-NN classifier. Accepts training points and class labels over a valid/ready stream, holds them in an NPoints-entry register table that drives the classifier's `points`/`classes` inputs in parallel, and issues one query point at a time on `din`. After a fixed classifier latency it captures the classifier's class output and returns it with a one-cycle valid strobe. It sequences the classifier so that neither the table nor the query changes while a classification is in flight.

## Interface
**Parameters**
- `NPoints`, 17: table depth; must match the classifier.
- `Classes`, 2: number of labels. Class width CW = $clog2(Classes).
- `KnnLatency`, 3: number of clock edges from the `din_o` update to the `result_i` sample point.
  - Use 3 when the classifier is built with flops.
  - Use 1 when the classifier is purely combinational.
  - Legal range is 1..15.

**Ports**
- `clk_i` in 1: single clock, rising edge.
- `rstn_i` in 1: reset, asynchronous and active-low.
- `clear_i` in 1: synchronous table flush.
- `load_valid_i` in 1: training entry valid.
- `load_point_i` in 32: training point; {x[31:16], y[15:0]}, unsigned.
- `load_class_i` in CW: training label.
- `load_ready_o` out 1: loader accepts a training entry.
- `query_valid_i` in 1: query valid.
- `query_point_i` in 32: query point.
- `query_ready_o` out 1: loader accepts a query.
- `points_o` out 32 x NPoints: table points, to the classifier.
- `classes_o` out CW x NPoints: table labels, to the classifier.
- `din_o` out 32: current query, to the classifier.
- `result_i` in CW: classifier output.
- `result_o` out CW: captured classification.
- `result_valid_o` out 1: one-cycle strobe for `result_o`.
- `count_o` out $clog2(NPoints+1): number of valid entries.
- `full_o` out 1: high when `count_o == NPoints`.

## Operation
**States**
- `FILL`: `count_o < NPoints`.
- `IDLE`: table full, no query in flight.
- `BUSY`: query in flight.

**Load path**
- A transfer occurs on `load_valid_i && load_ready_o`.
- `load_ready_o = (state==FILL) && !clear_i`. The replace option (see Configuration) extends this.
- Each accepted entry is written to `points_o[wr_ptr]` / `classes_o[wr_ptr]`.
- `wr_ptr` increments by one per entry. `count_o` increments and saturates at NPoints.
- When `count_o` reaches NPoints the state moves FILL→IDLE and `wr_ptr` wraps to 0.

**Query path**
- `query_ready_o = (state==IDLE) && !clear_i`.
- On a query handshake:
  - `din_o <= query_point_i`.
  - The latency counter loads `KnnLatency`.
  - The state moves IDLE→BUSY.
- In BUSY the counter decrements every cycle. When it reaches 0:
  - `result_o <= result_i`.
  - `result_valid_o` pulses high for exactly one cycle.
  - The state returns to IDLE.
- `din_o` holds its value until the next query handshake.
- In BUSY both `load_ready_o` and `query_ready_o` are 0. The table and the query are frozen.

**Clear**
- `clear_i` has highest priority. While it is high, both readys are 0.
- At the edge: `count_o=0`, `wr_ptr=0`, state→FILL.
- An in-flight query is aborted: no `result_valid_o` pulse is produced.
- Table contents and `din_o` are retained but are logically invalid.

**Arithmetic**
- Counters are unsigned. There is no arithmetic on point data.

## Timing
- Reset values:
  - All `points_o` and `classes_o` entries = 0.
  - `din_o` = 0; `result_o` = 0; `result_valid_o` = 0.
  - `count_o` = 0; `full_o` = 0.
  - `load_ready_o` = 1 and `query_ready_o` = 0 (state FILL).
- Query handshake at edge E0 → `din_o` is new after E0 → `result_i` is sampled at edge E0+KnnLatency → `result_valid_o` is high during the cycle after that edge.
- Query throughput: one query per KnnLatency+1 cycles. `query_ready_o` reasserts in the same cycle as `result_valid_o`.
- Table loading takes NPoints back-to-back cycles at full rate.
- The readys depend combinationally only on state and `clear_i`. There is no combinational path from a valid to a ready.
- Reset asserted mid-operation returns all state to reset values immediately. No result is produced.

## Configuration
- Macro `KNN_LOADER_REPLACE_EN`.
- **Defined**:
  - In IDLE, `load_ready_o` is 1.
  - Each load overwrites the oldest entry at `wr_ptr`, and `wr_ptr` wraps from NPoints-1 to 0.
  - `count_o` stays at NPoints and the state stays IDLE.
  - A load and a query accepted in the same IDLE cycle both commit at the same edge, so the query is classified against the updated table.
- **Not defined**:
  - In IDLE, `load_ready_o` is 0. Loads are backpressured until `clear_i`.

## Test plan
- Reset, then 17 back-to-back loads (point i = {i, 2i}, class = i[0]) → `count_o` increments 1..17, `full_o` is high after the 17th edge, `load_ready_o` drops, and `points_o[5]` = 0x0005_000A.
- Full table, query 0x0003_0006 at edge E0 with `KnnLatency`=3 and `result_i` forced to 1 from E0+2 → `result_valid_o` is high for exactly one cycle after E0+3, `result_o`=1, and `query_ready_o` is low for 3 cycles.
- Query accepted, `clear_i` pulsed 1 cycle later → no `result_valid_o` pulse, `count_o`=0, `load_ready_o`=1 in the next cycle.
- Query presented during FILL (`count_o`=10) → `query_ready_o`=0 and `din_o` unchanged; the same query is accepted once `count_o` reaches 17.
- With `KNN_LOADER_REPLACE_EN` defined, full table, 18th load {0xFFFF, 0xFFFF} with class 1 → `points_o[0]` is replaced, `count_o` stays 17, and the next load writes index 1. Without the macro, the same load stalls with `load_ready_o`=0.
- Assert `rstn_i` low mid-BUSY → all outputs return to their reset values asynchronously and no result strobe follows.

Source files
------------

// File: rtl/knn_train_loader.sv
// Training-table loader and query sequencer in front of the k-NN classifier.
// Optional macro KNN_LOADER_REPLACE_EN: oldest-entry replacement while the table is full.
module knn_train_loader #(
    parameter int NPoints    = 17,
    parameter int Classes    = 2,
    parameter int KnnLatency = 3,
    localparam int CW = (Classes > 2) ? $clog2(Classes) : 1,
    localparam int NW = $clog2(NPoints + 1),
    localparam int PW = (NPoints > 1) ? $clog2(NPoints) : 1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          clear_i,
    input  logic                          load_valid_i,
    input  logic [31:0]                   load_point_i,
    input  logic [CW-1:0]                 load_class_i,
    output logic                          load_ready_o,
    input  logic                          query_valid_i,
    input  logic [31:0]                   query_point_i,
    output logic                          query_ready_o,
    output logic [NPoints-1:0][31:0]      points_o,
    output logic [NPoints-1:0][CW-1:0]    classes_o,
    output logic [31:0]                   din_o,
    input  logic [CW-1:0]                 result_i,
    output logic [CW-1:0]                 result_o,
    output logic                          result_valid_o,
    output logic [NW-1:0]                 count_o,
    output logic                          full_o
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    localparam logic [NW-1:0] LP_FULL      = NW'(NPoints);
    localparam logic [NW-1:0] LP_FILL_LAST = NW'(NPoints - 1);
    localparam logic [PW-1:0] LP_PTR_LAST  = PW'(NPoints - 1);
    localparam logic [3:0]    LP_LAT       = 4'(KnnLatency);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NPoints-1:0][31:0]   r_points;
    logic [NPoints-1:0][CW-1:0] r_classes;
    logic [PW-1:0]              r_wr_ptr;
    logic [NW-1:0]              r_count;
    logic [3:0]                 r_lat;
    logic [31:0]                r_din;
    logic [CW-1:0]              r_result;
    logic                       r_result_valid;
    logic                       w_load_fire;
    logic                       w_query_fire;
    logic                       w_lat_done;

    assign w_load_fire  = load_valid_i && load_ready_o;
    assign w_query_fire = query_valid_i && query_ready_o;
    assign w_lat_done   = (r_state == S_BUSY) && (r_lat == 4'd1);

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_load_fire && (r_count == LP_FILL_LAST)) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
                S_IDLE: begin
                    if (w_query_fire) begin
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (w_lat_done) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    // Ready outputs depend only on state and clear, never on a valid.
    always_comb begin
        load_ready_o  = 1'b0;
        query_ready_o = 1'b0;
        if (clear_i) begin
            load_ready_o  = 1'b0;
            query_ready_o = 1'b0;
        end else begin
            case (r_state)
                S_FILL: load_ready_o = 1'b1;
                S_IDLE: begin
                    query_ready_o = 1'b1;
`ifdef KNN_LOADER_REPLACE_EN
                    load_ready_o  = 1'b1;
`else
                    load_ready_o  = 1'b0;
`endif
                end
                S_BUSY:  load_ready_o = 1'b0;
                default: load_ready_o = 1'b0;
            endcase
        end
    end

    // Table storage; contents survive clear and are simply re-counted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_points  <= '0;
            r_classes <= '0;
        end else if (w_load_fire) begin
            r_points[r_wr_ptr]  <= load_point_i;
            r_classes[r_wr_ptr] <= load_class_i;
        end else begin
            r_points  <= r_points;
            r_classes <= r_classes;
        end
    end

    // Write pointer wraps after the last slot; count saturates at full.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_load_fire) begin
            r_wr_ptr <= (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            r_count  <= (r_count == LP_FULL) ? r_count : r_count + NW'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
            r_count  <= r_count;
        end
    end

    // Query launch, latency countdown and result capture; clear aborts silently.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_din          <= '0;
            r_lat          <= 4'd0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (clear_i) begin
            r_lat          <= 4'd0;
            r_result_valid <= 1'b0;
        end else if (w_query_fire) begin
            r_din          <= query_point_i;
            r_lat          <= LP_LAT;
            r_result_valid <= 1'b0;
        end else if (w_lat_done) begin
            r_lat          <= 4'd0;
            r_result       <= result_i;
            r_result_valid <= 1'b1;
        end else if (r_state == S_BUSY) begin
            r_lat          <= r_lat - 4'd1;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
        end
    end

    assign points_o       = r_points;
    assign classes_o      = r_classes;
    assign din_o          = r_din;
    assign result_o       = r_result;
    assign result_valid_o = r_result_valid;
    assign count_o        = r_count;
    assign full_o         = (r_count == LP_FULL);

endmodule
